// File: rtl/pcie_sw_pkg.sv
// Shared constants and FSM encoding for the PCIe switch ingress/egress datapath.
package pcie_sw_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DEST_W    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_grant_4.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo 4.
module rr_grant_4
    import pcie_sw_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [1:0]           gnt_idx
);

    logic [1:0] w_idx;
    logic       w_found;

    // Offsets 1..4 make the port just granted the lowest priority next time.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        w_found = 1'b0;
        w_idx   = ptr;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx = ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                gnt_idx = w_idx;
                gnt     = NUM_PORTS'(1) << w_idx;
            end
        end
    end

endmodule

// File: rtl/pop_arbiter_4x4.sv
// Round-robin consumer of four ingress FIFOs; routes each popped word to one
// of four egress FIFOs using the destination field carried in the word.
module pop_arbiter_4x4
    import pcie_sw_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEST_MSB  = 7
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   fifo_empty_in,
    input  logic [NUM_PORTS-1:0]   fifo_error_in,
    input  logic [4*DATA_SIZE-1:0] data_in,
    input  logic [NUM_PORTS-1:0]   pause_in,
    output logic [NUM_PORTS-1:0]   pop,
    output logic [NUM_PORTS-1:0]   push_out,
    output logic [DATA_SIZE-1:0]   data_out,
    output logic                   error_out
);

    state_t                 r_state;
    logic [1:0]             r_rrPtr;
    logic                   r_v1;
    logic [1:0]             r_selQ;
    logic [NUM_PORTS-1:0]   r_pushOut;
    logic [DATA_SIZE-1:0]   r_dataOut;
    logic                   r_error;

    logic [NUM_PORTS-1:0]   w_gnt;
    logic [1:0]             w_gntIdx;
    logic                   w_popEn;
    logic [NUM_PORTS-1:0]   w_pop;
    logic [DATA_SIZE-1:0]   w_lane [NUM_PORTS];
    logic [DATA_SIZE-1:0]   w_word;
    logic [DEST_W-1:0]      w_dest;

    rr_grant_4 u_grant (
        .req     (~fifo_empty_in),
        .ptr     (r_rrPtr),
        .gnt     (w_gnt),
        .gnt_idx (w_gntIdx)
    );

    // Destination is unknown until the word returns, so any pause halts every port.
    assign w_popEn = !reset && (r_state != PAUSE) && !(|pause_in);
    assign w_pop   = w_popEn ? w_gnt : '0;
    assign pop     = w_pop;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        assign w_lane[g] = data_in[g*DATA_SIZE +: DATA_SIZE];
    end

    assign w_word = w_lane[r_selQ];
    assign w_dest = w_word[DEST_MSB -: DEST_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|pause_in)
                        r_state <= PAUSE;
                    else if (!(&fifo_empty_in))
                        r_state <= ACTIVE;
                end
                ACTIVE: begin
                    if (|pause_in)
                        r_state <= PAUSE;
                    else if (&fifo_empty_in)
                        r_state <= IDLE;
                end
                PAUSE: begin
                    if (!(|pause_in))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pointer starts at 3 so the first grant after reset lands on port 0.
    always_ff @(posedge clk) begin
        if (reset)
            r_rrPtr <= 2'd3;
        else if (|w_pop)
            r_rrPtr <= w_gntIdx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_selQ    <= '0;
            r_pushOut <= '0;
            r_dataOut <= '0;
        end else begin
            r_v1   <= |w_pop;
            r_selQ <= w_gntIdx;
            if (r_v1) begin
                r_dataOut <= w_word;
                r_pushOut <= NUM_PORTS'(1) << w_dest;
            end else begin
                r_pushOut <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_error <= 1'b0;
        else
            r_error <= r_error | (|fifo_error_in);
    end

    assign push_out  = r_pushOut;
    assign data_out  = r_dataOut;
    assign error_out = r_error;

endmodule

// File: tb/tb_pop_arbiter_4x4.sv
// Directed bench for pop_arbiter_4x4: reset, fairness, single source, pause,
// sticky error and reset in the middle of traffic.
module tb_pop_arbiter_4x4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_empty_in;
    logic [3:0]  fifo_error_in;
    logic [31:0] data_in;
    logic [3:0]  pause_in;
    logic [3:0]  pop;
    logic [3:0]  push_out;
    logic [7:0]  data_out;
    logic        error_out;

    int errors = 0;
    int checks = 0;

    pop_arbiter_4x4 #(.DATA_SIZE(8), .DEST_MSB(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty_in (fifo_empty_in),
        .fifo_error_in (fifo_error_in),
        .data_in       (data_in),
        .pause_in      (pause_in),
        .pop           (pop),
        .push_out      (push_out),
        .data_out      (data_out),
        .error_out     (error_out)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic rst, input logic [3:0] empty,
                                 input logic [3:0] err, input logic [3:0] pause);
        @(negedge clk);
        reset         = rst;
        fifo_empty_in = empty;
        fifo_error_in = err;
        pause_in      = pause;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] words [4];
        logic [3:0] expPop;
        logic [3:0] expPush;

        words[0] = 8'h05;
        words[1] = 8'h41;
        words[2] = 8'h82;
        words[3] = 8'hC3;

        reset = 1'b1; fifo_empty_in = 4'hF; fifo_error_in = 4'h0; pause_in = 4'h0;
        data_in = 32'h0;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 2; i++) begin
            data_in = $urandom;
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
            checkOutput("reset_pop", {4'h0, pop}, 8'h00);
        end
        checkOutput("reset_push", {4'h0, push_out}, 8'h00);
        checkOutput("reset_data", data_out, 8'h00);
        checkOutput("reset_err", {7'h0, error_out}, 8'h00);

        $display("[TB] fairness");
        data_in = {words[3], words[2], words[1], words[0]};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, (i < 5) ? 4'b0000 : 4'b1111, 4'h0, 4'h0);
            expPop  = (i < 5) ? (4'b0001 << (i % 4)) : 4'b0000;
            expPush = (i >= 2) ? (4'b0001 << ((i - 2) % 4)) : 4'b0000;
            checkOutput($sformatf("fair_pop%0d", i), {4'h0, pop}, {4'h0, expPop});
            checkOutput($sformatf("fair_push%0d", i), {4'h0, push_out}, {4'h0, expPush});
            if (i >= 2)
                checkOutput($sformatf("fair_data%0d", i), data_out, words[(i - 2) % 4]);
        end

        $display("[TB] single source");
        data_in = {words[3], words[2], words[1], 8'h85};
        applyStimulus(1'b0, 4'b1110, 4'h0, 4'h0);
        checkOutput("single_pop", {4'h0, pop}, 8'h01);
        checkOutput("single_push_n", {4'h0, push_out}, 8'h00);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("single_pop_n1", {4'h0, pop}, 8'h00);
        checkOutput("single_push_n1", {4'h0, push_out}, 8'h00);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("single_push_n2", {4'h0, push_out}, 8'h04);
        checkOutput("single_data_n2", data_out, 8'h85);

        $display("[TB] pause");
        data_in = {words[3], words[2], words[1], words[0]};
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0);
        checkOutput("pause_p0_pop", {4'h0, pop}, 8'h02);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0);
        checkOutput("pause_p1_pop", {4'h0, pop}, 8'h04);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'b0010);
        checkOutput("pause_p2_pop", {4'h0, pop}, 8'h00);
        checkOutput("pause_p2_push", {4'h0, push_out}, 8'h02);
        checkOutput("pause_p2_data", data_out, 8'h41);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'b0010);
        checkOutput("pause_p3_pop", {4'h0, pop}, 8'h00);
        checkOutput("pause_p3_push", {4'h0, push_out}, 8'h04);
        checkOutput("pause_p3_data", data_out, 8'h82);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'b0010);
        checkOutput("pause_p4_pop", {4'h0, pop}, 8'h00);
        checkOutput("pause_p4_push", {4'h0, push_out}, 8'h00);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0);
        checkOutput("pause_p5_pop", {4'h0, pop}, 8'h00);
        checkOutput("pause_p5_push", {4'h0, push_out}, 8'h00);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0);
        checkOutput("pause_p6_pop", {4'h0, pop}, 8'h08);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0);
        checkOutput("pause_p7_pop", {4'h0, pop}, 8'h01);
        checkOutput("pause_p7_push", {4'h0, push_out}, 8'h00);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("pause_p8_pop", {4'h0, pop}, 8'h00);
        checkOutput("pause_p8_push", {4'h0, push_out}, 8'h08);
        checkOutput("pause_p8_data", data_out, 8'hC3);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("pause_p9_push", {4'h0, push_out}, 8'h01);
        checkOutput("pause_p9_data", data_out, 8'h05);

        $display("[TB] sticky error");
        applyStimulus(1'b0, 4'b1111, 4'b0100, 4'h0);
        checkOutput("err_e0", {7'h0, error_out}, 8'h00);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("err_e1", {7'h0, error_out}, 8'h01);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("err_e2", {7'h0, error_out}, 8'h01);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0);
        checkOutput("rst_r0_pop", {4'h0, pop}, 8'h02);
        applyStimulus(1'b1, 4'b0000, 4'h0, 4'h0);
        checkOutput("rst_r1_pop", {4'h0, pop}, 8'h00);
        applyStimulus(1'b0, 4'b0000, 4'h0, 4'h0);
        checkOutput("rst_r2_push", {4'h0, push_out}, 8'h00);
        checkOutput("rst_r2_data", data_out, 8'h00);
        checkOutput("rst_r2_err", {7'h0, error_out}, 8'h00);
        checkOutput("rst_r2_pop", {4'h0, pop}, 8'h01);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("rst_r3_push", {4'h0, push_out}, 8'h00);
        applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0);
        checkOutput("rst_r4_push", {4'h0, push_out}, 8'h01);
        checkOutput("rst_r4_data", data_out, 8'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
